// File: rtl/mod9_seq_monitor.sv
// Sequence checker for a mod-MOD counter: locks on 0, counts wraps, flags and counts errors.
// Optional MOD9_MON_CAPTURE_EN adds err_got/err_exp capture of the first error.
module mod9_seq_monitor #(
    parameter int unsigned MOD     = 9,
    parameter int unsigned W       = 5,
    parameter int unsigned WRAPS_W = 8,
    parameter int unsigned ERRS_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cnt_valid,
    input  logic [W-1:0]       cnt_in,
    input  logic               clr,
    output logic               locked,
    output logic               wrap_pulse,
    output logic [WRAPS_W-1:0] wraps,
    output logic               err_pulse,
    output logic               err_sticky,
    output logic [ERRS_W-1:0]  err_cnt
`ifdef MOD9_MON_CAPTURE_EN
    ,
    output logic [W-1:0]       err_got,
    output logic [W-1:0]       err_exp
`endif
);

    typedef enum logic [0:0] {StSearch, StLock} state_t;

    localparam logic [W-1:0] LastVal = W'(MOD - 1);
    localparam logic [W-1:0] FirstExp = (MOD > 1) ? W'(1) : '0;

    state_t              state_q, state_d;
    logic [W-1:0]        exp_q, exp_d;
    logic [WRAPS_W-1:0]  wraps_q, wraps_d;
    logic [ERRS_W-1:0]   err_cnt_q, err_cnt_d;
    logic                err_sticky_q, err_sticky_d;
    logic                wrap_pulse_q, err_pulse_q;
    logic                wrap_ev, err_ev;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        wrap_ev      = 1'b0;
        err_ev       = 1'b0;
        if (cnt_valid) begin
            unique case (state_q)
                StSearch: begin
                    if (cnt_in == '0) begin
                        state_d = StLock;
                        exp_d   = FirstExp;
                    end else if (32'(cnt_in) >= MOD) begin
                        err_ev = 1'b1;
                    end
                end
                StLock: begin
                    if (cnt_in == exp_q) begin
                        exp_d = (exp_q == LastVal) ? '0 : exp_q + W'(1);
                        wrap_ev = (cnt_in == LastVal);
                    end else begin
                        // Offending sample is dropped; relock needs a fresh 0.
                        err_ev  = 1'b1;
                        state_d = StSearch;
                        exp_d   = '0;
                    end
                end
                default: begin
                    state_d = StSearch;
                    exp_d   = '0;
                end
            endcase
        end

        wraps_d      = wraps_q + WRAPS_W'(wrap_ev);
        err_sticky_d = err_sticky_q | err_ev;
        err_cnt_d    = err_cnt_q;
        if (err_ev && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRS_W'(1);
        end
        if (clr) begin
            wraps_d      = '0;
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSearch;
            exp_q        <= '0;
            wraps_q      <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            wraps_q      <= wraps_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            wrap_pulse_q <= wrap_ev;
            err_pulse_q  <= err_ev;
        end
    end

    assign locked     = (state_q == StLock);
    assign wrap_pulse = wrap_pulse_q;
    assign wraps      = wraps_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

`ifdef MOD9_MON_CAPTURE_EN
    logic [W-1:0] err_got_q, err_exp_q;

    // Only the first error since reset/clear is recorded.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_got_q <= '0;
            err_exp_q <= '0;
        end else if (err_ev && !err_sticky_q) begin
            err_got_q <= cnt_in;
            err_exp_q <= exp_q;
        end
    end

    assign err_got = err_got_q;
    assign err_exp = err_exp_q;
`endif

endmodule

// File: tb/tb_mod9_seq_monitor.sv
// Randomised and directed bench for mod9_seq_monitor against an arithmetic reference model.
// Define MOD9_MON_CAPTURE_EN for both files to also check the error-capture outputs.
module tb_mod9_seq_monitor;

    localparam int MOD = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cnt_valid = 1'b0;
    logic [4:0] cnt_in = '0;
    logic       clr = 1'b0;
    logic       locked, wrap_pulse, err_pulse, err_sticky;
    logic [7:0] wraps;
    logic [3:0] err_cnt;
`ifdef MOD9_MON_CAPTURE_EN
    logic [4:0] err_got, err_exp;
`endif

    mod9_seq_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_valid  (cnt_valid),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .wraps      (wraps),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
`ifdef MOD9_MON_CAPTURE_EN
        ,
        .err_got    (err_got),
        .err_exp    (err_exp)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: plain integers, next-expected value by modulo arithmetic.
    bit m_locked, m_wp, m_ep, m_sticky;
    int m_exp, m_wraps, m_errs, m_got, m_expc;

    task automatic model_update(input bit r, input bit v, input int val, input bit c);
        bit was_locked;
        int old_exp;
        if (r) begin
            m_locked = 0; m_wp = 0; m_ep = 0; m_sticky = 0;
            m_exp = 0; m_wraps = 0; m_errs = 0; m_got = 0; m_expc = 0;
            return;
        end
        was_locked = m_locked;
        old_exp = m_exp;
        m_wp = 0;
        m_ep = 0;
        if (v) begin
            if (!m_locked) begin
                if (val == 0) begin
                    m_locked = 1;
                    m_exp = 1 % MOD;
                end else if (val >= MOD) begin
                    m_ep = 1;
                end
            end else if (val == m_exp) begin
                m_wp = (val == MOD - 1);
                m_exp = (m_exp + 1) % MOD;
            end else begin
                m_ep = 1;
                m_locked = 0;
                m_exp = 0;
            end
        end
        if (m_ep) begin
            if (!m_sticky) begin
                m_got = val;
                m_expc = was_locked ? old_exp : 0;
            end
            m_sticky = 1;
            if (m_errs < 15) m_errs++;
        end
        if (m_wp) m_wraps = (m_wraps + 1) % 256;
        if (c) begin
            m_wraps = 0; m_errs = 0; m_sticky = 0; m_got = 0; m_expc = 0;
        end
    endtask

    task automatic step(input bit r, input bit v, input int val, input bit c);
        rst = r;
        cnt_valid = v;
        cnt_in = val[4:0];
        clr = c;
        @(posedge clk);
        model_update(r, v, val, c);
        cyc++;
        #1;
    endtask

    function automatic logic [15:0] dut_vec();
        return {locked, wrap_pulse, wraps, err_pulse, err_sticky, err_cnt};
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [7:0] w;
        logic [3:0] e;
        w = m_wraps[7:0];
        e = m_errs[3:0];
        return {m_locked, m_wp, w, m_ep, m_sticky, e};
    endfunction

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        n_cmp++;
        if (dut_vec() !== 16'h0) begin
            n_err++;
            $display("FAIL reset cyc%0d: got %h want %h", cyc, dut_vec(), 16'h0);
        end
    endtask

    task automatic test_wrap_sequence();
        int pulses = 0;
        for (int i = 0; i < 19; i++) begin
            step(0, 1, i % 9, 0);
            if (wrap_pulse === 1'b1) pulses++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap_seq cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 2 || wraps !== 8'd2 || err_cnt !== 4'd0 || err_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_totals: got pulses=%0d wraps=%0d errs=%0d want 2/2/0",
                     pulses, wraps, err_cnt);
        end
    endtask

    task automatic test_skip_error();
        int seq[7] = '{0, 1, 2, 4, 5, 0, 1};
        step(1, 0, 0, 0);
        foreach (seq[i]) begin
            step(0, 1, seq[i], 0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL skip_err cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL skip_relock: got locked=%b errs=%0d want 1/1", locked, err_cnt);
        end
    endtask

    task automatic test_search_oor();
        int seq[3] = '{12, 3, 7};
        step(1, 0, 0, 0);
        foreach (seq[i]) begin
            step(0, 1, seq[i], 0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL search_oor cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, i % 9, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0);
            step(0, 1, 3, 0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL saturate cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (err_cnt !== 4'd15 || wraps !== 8'd1) begin
            n_err++;
            $display("FAIL sat_level: got errs=%0d wraps=%0d want 15/1", err_cnt, wraps);
        end
        step(0, 0, 0, 1);
        n_cmp++;
        if (err_cnt !== 4'd0 || err_sticky !== 1'b0 || wraps !== 8'd0) begin
            n_err++;
            $display("FAIL sat_clr: got errs=%0d sticky=%b wraps=%0d want 0/0/0",
                     err_cnt, err_sticky, wraps);
        end
    endtask

    task automatic test_valid_gap();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, i, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 31, 0);
        step(0, 1, 5, 0);
        step(0, 1, 6, 0);
        step(1, 1, 7, 0);
        step(0, 1, 0, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec() || locked !== 1'b1 || err_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL valid_gap cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_clr_collision();
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, i, i == 8);
        n_cmp++;
        if (wrap_pulse !== 1'b1 || wraps !== 8'd0 || dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL clr_wrap: got %h want %h", dut_vec(), exp_vec());
        end
        step(0, 1, 4, 1);
        n_cmp++;
        if (err_pulse !== 1'b1 || err_cnt !== 4'd0 || locked !== 1'b0 ||
            dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL clr_err: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

`ifdef MOD9_MON_CAPTURE_EN
    task automatic test_capture();
        int seq[6] = '{0, 1, 2, 7, 0, 5};
        step(1, 0, 0, 0);
        foreach (seq[i]) step(0, 1, seq[i], 0);
        n_cmp++;
        if (err_got !== 5'd7 || err_exp !== 5'd3 || err_cnt !== 4'd2) begin
            n_err++;
            $display("FAIL capture: got got=%0d exp=%0d errs=%0d want 7/3/2",
                     err_got, err_exp, err_cnt);
        end
    endtask
`endif

    task automatic test_random();
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit r, v, c;
            int val;
            r = ($urandom_range(0, 79) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            val = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : m_exp;
            step(r, v, val, c);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", cyc, dut_vec(), exp_vec());
            end
`ifdef MOD9_MON_CAPTURE_EN
            n_cmp++;
            if (err_got !== m_got[4:0] || err_exp !== m_expc[4:0]) begin
                n_err++;
                $display("FAIL random_cap cyc%0d: got %0d/%0d want %0d/%0d",
                         cyc, err_got, err_exp, m_got, m_expc);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_wrap_sequence();
        test_skip_error();
        test_search_oor();
        test_saturation();
        test_valid_gap();
        test_clr_collision();
`ifdef MOD9_MON_CAPTURE_EN
        test_capture();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
